bram_arbiter: RTL and testbench

- Shares one port of the dual-port block RAM between NUM_REQ requesters (e.g. load/store unit, debug loader, DMA) using round-robin arbitration.
- Requests and responses use valid/ready handshakes.
- Hides the RAM's one-cycle read latency and no-change write mode.
- Stalls the RAM by deasserting its enable, so the RAM output latch holds read data while a response is back-pressured.

---
 rtl/bram_arb_pkg.sv | 46 ++++
 rtl/bram_arbiter_rr.sv | 43 ++++
 rtl/bram_arbiter.sv | 91 +++++++++
 tb/tb_bram_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block RAM arbiter.
// Holds default widths, the request bundle and the round-robin pick function.
package bram_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int STRB_WIDTH = DATA_WIDTH_DEF / 8;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
  } bram_req_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid index searching cyclically upward from rr.
  // Walk offsets high to low so the smallest offset is the last hit.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         rr,
    input int                 n
  );
    rr_pick_t   p;
    int         k;
    logic [2:0] kk;
    p = '0;
    for (int o = MAX_REQ - 1; o >= 0; o--) begin
      if (o < n) begin
        k = int'(rr) + o;
        if (k >= n) k = k - n;
        kk = 3'(k);
        if (valid[kk]) begin
          p.found = 1'b1;
          p.idx   = kk;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr.sv
// Round-robin arbiter with its own rotating priority pointer.
// Ports: clk, reset, valid, advance -> grant (one-hot), grant_idx, found.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               found
);

  logic [2:0]         rr;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  assign valid_ext = MAX_REQ'(valid);
  assign pick      = rr_pick(valid_ext, rr, NUM_REQ);
  assign found     = pick.found;
  assign grant_idx = IW'(pick.idx);

  always_comb begin
    grant = '0;
    if (pick.found) grant[grant_idx] = 1'b1;
  end

  // Priority moves just past the winner, so a busy
  // requester cannot starve the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= '0;
    end else if (advance && pick.found) begin
      if (pick.idx == 3'(NUM_REQ - 1)) rr <= '0;
      else rr <= pick.idx + 3'd1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one block RAM port between NUM_REQ valid/ready requesters.
// Ports: req_* (requests), rsp_* (responses), bram_* (RAM port).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int SW = DATA_WIDTH / 8,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*SW-1:0]         req_wstrb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          bram_en,
  output logic                          bram_rst,
  output logic [SW-1:0]                 bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_di,
  input  logic [DATA_WIDTH-1:0]         bram_do
);

  logic               pend;
  logic               is_wr;
  logic [IW-1:0]      owner;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               found;
  logic               owner_rdy;
  logic               can_issue;
  logic               issue;
  logic [SW-1:0]      g_wstrb;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .valid     (req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (gidx),
    .found     (found)
  );

  // A retiring response frees the port in the same cycle.
  assign owner_rdy = rsp_ready[owner];
  assign can_issue = !reset && (!pend || owner_rdy);
  assign issue     = can_issue && found;
  assign req_ready = can_issue ? grant : '0;

  assign g_wstrb   = req_wstrb[gidx*SW +: SW];

  // Enable only on issue: a stalled RAM keeps its output
  // latch, which is what holds rsp_rdata under back-pressure.
  assign bram_en   = reset || issue;
  assign bram_rst  = reset;
  assign bram_we   = issue ? g_wstrb : '0;
  assign bram_addr = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign bram_di   = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rsp_valid = '0;
    if (pend) rsp_valid[owner] = 1'b1;
  end

  // Writes in no-change mode leave stale data on bram_do.
  assign rsp_rdata = (pend && !is_wr) ? bram_do : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend  <= 1'b0;
      is_wr <= 1'b0;
      owner <= '0;
    end else if (issue) begin
      pend  <= 1'b1;
      is_wr <= |g_wstrb;
      owner <= gidx;
    end else if (pend && owner_rdy) begin
      pend  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural RAM and scoreboard.
// Ports: none; drives the DUT and a no-change-mode RAM model.
module tb_bram_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            bram_en;
  logic            bram_rst;
  logic [SW-1:0]   bram_we;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_di;
  logic [DW-1:0]   bram_do;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .bram_en   (bram_en),
    .bram_rst  (bram_rst),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_di   (bram_di),
    .bram_do   (bram_do)
  );

  // RAM model, no-change write mode; ld_* is a bench-only load port.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] dout;
  logic          ld_en = 1'b0;
  logic          ld_dout = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  assign bram_do = dout;

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_dout) dout <= ld_data;
      else mem[ld_addr] <= ld_data;
    end else if (bram_en === 1'b1) begin
      if (bram_rst) begin
        dout <= '0;
      end else if (|bram_we) begin
        for (int b = 0; b < SW; b++)
          if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_di[b*8 +: 8];
      end else begin
        dout <= mem[bram_addr];
      end
    end
  end

  // Scoreboard: reference memory plus expected-response queue.
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] ref_mem [1024];
  logic          mon_en = 1'b0;
  int            issued;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;
  logic [SW-1:0] ms;

  always @(negedge clk) begin
    #4;
    if (ld_en && !ld_dout) ref_mem[ld_addr] = ld_data;
    if (reset) begin
      sb.delete();
    end else if (mon_en) begin
      checks++;
      if ((rsp_valid & (rsp_valid - 1'b1)) != '0) begin
        errors++;
        $display("FAIL sb_onehot rsp_valid got=%b", rsp_valid);
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected rsp on %0d data=%h", i, rsp_rdata);
          end else begin
            e = sb.pop_front();
            if (e.idx != i || rsp_rdata !== e.data) begin
              errors++;
              $display("FAIL sb_rsp got=%0d:%h exp=%0d:%h",
                       i, rsp_rdata, e.idx, e.data);
            end
          end
        end
      end
      issued = 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          issued++;
          ma = req_addr[i*AW +: AW];
          md = req_wdata[i*DW +: DW];
          ms = req_wstrb[i*SW +: SW];
          if (ms == '0) begin
            sb.push_back('{i, ref_mem[ma]});
          end else begin
            for (int b = 0; b < SW; b++)
              if (ms[b]) ref_mem[ma][b*8 +: 8] = md[b*8 +: 8];
            sb.push_back('{i, '0});
          end
        end
      end
      checks++;
      if (issued > 1 || bram_en !== (issued != 0)) begin
        errors++;
        $display("FAIL sb_issue bram_en=%b issued=%0d", bram_en, issued);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_dout = 1'b0; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ld_en = 1'b1; ld_dout = 1'b1; ld_data = 32'h5A5A5A5A;
    @(negedge clk);
    ld_en = 1'b0; ld_dout = 1'b0;
    reset = 1'b1; req_valid = '1; rsp_ready = '0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #4;
      checks++;
      if (bram_en !== 1'b1 || bram_rst !== 1'b1 || bram_we !== '0) begin
        errors++;
        $display("FAIL rst_bram en=%b rst=%b we=%b exp=1,1,0", bram_en, bram_rst, bram_we);
      end
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL rst_ready got=%b exp=00", req_ready);
      end
    end
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    #4;
    checks++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL post_rst rsp_valid=%b rdata=%h ready=%b exp=0", rsp_valid, rsp_rdata, req_ready);
    end
    checks++;
    if (bram_rst !== 1'b0 || bram_en !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL post_rst_bram rst=%b en=%b latch=%h exp=0", bram_rst, bram_en, dout);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    rsp_ready = '1;
    set_req(0, 1'b1, 10'h010, '0, '0);
    #4;
    checks++;
    if (req_ready !== 2'b01 || bram_en !== 1'b1 || bram_addr !== 10'h010 || bram_we !== '0) begin
      errors++;
      $display("FAIL rd_issue ready=%b en=%b addr=%h we=%b exp=01,1,010,0", req_ready, bram_en, bram_addr, bram_we);
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    #4;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_rsp valid=%b data=%h exp=01,deadbeef", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    #4;
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL rd_retire valid=%b exp=00", rsp_valid);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_req(1, 1'b1, 10'h020, 32'h12345678, 4'b0110);
    #4;
    checks++;
    if (req_ready !== 2'b10 || bram_we !== 4'b0110 || bram_di !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_issue ready=%b we=%b di=%h exp=10,0110,12345678", req_ready, bram_we, bram_di);
    end
    @(negedge clk);
    set_req(1, 1'b1, 10'h020, '0, '0);
    #4;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== '0 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL wr_rsp valid=%b data=%h ready=%b exp=10,0,10", rsp_valid, rsp_rdata, req_ready);
    end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    #4;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hAA3456AA) begin
      errors++;
      $display("FAIL raw_rsp valid=%b data=%h exp=10,aa3456aa", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    logic [N-1:0] prev;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_req(0, 1'b1, 10'h030, '0, '0);
        set_req(1, 1'b1, 10'h031, '0, '0);
      end
      #4;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL arb_grant c=%0d got=%b exp=%b", c, req_ready, exp_g);
      end
      if (c > 0) begin
        checks++;
        if (rsp_valid !== prev) begin
          errors++;
          $display("FAIL arb_rsp c=%0d got=%b exp=%b", c, rsp_valid, prev);
        end
      end
      prev = exp_g;
    end
    @(negedge clk);
    req_valid = '0;
    #4;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h31313131) begin
      errors++;
      $display("FAIL arb_last valid=%b data=%h exp=10,31313131", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    rsp_ready = 2'b10;
    set_req(0, 1'b1, 10'h040, '0, '0);
    #4;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_issue ready=%b exp=01", req_ready);
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 10'h041, '0, '0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hCAFEF00D || bram_en !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold k=%0d valid=%b data=%h en=%b ready=%b exp=01,cafef00d,0,00", k, rsp_valid, rsp_rdata, bram_en, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #4;
    checks++;
    if (req_ready !== 2'b10 || bram_en !== 1'b1 || rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL bp_release ready=%b en=%b valid=%b exp=10,1,01", req_ready, bram_en, rsp_valid);
    end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    #4;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h11112222) begin
      errors++;
      $display("FAIL bp_next valid=%b data=%h exp=10,11112222", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // rr left at 1, reset must bring it back to 0
    @(negedge clk);
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 10'h040, '0, '0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b1, 10'h040, '0, '0);
    set_req(1, 1'b1, 10'h041, '0, '0);
    #4;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_rr ready=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    // pending response on requester 1 dropped by reset
    rsp_ready = 2'b00;
    set_req(1, 1'b1, 10'h041, '0, '0);
    #4;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL mid_issue ready=%b exp=10", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #4;
    checks++;
    if (rsp_valid !== 2'b10) begin
      errors++;
      $display("FAIL mid_pend valid=%b exp=10", rsp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 10'h040, '0, '0);
    set_req(1, 1'b1, 10'h041, '0, '0);
    #4;
    checks++;
    if (rsp_valid !== '0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_after valid=%b ready=%b exp=00,01", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #4;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mid_rsp valid=%b data=%h exp=01,cafef00d", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = '0;
    preload(10'h010, 32'hDEADBEEF);
    preload(10'h020, 32'hAAAAAAAA);
    preload(10'h030, 32'h30303030);
    preload(10'h031, 32'h31313131);
    preload(10'h040, 32'hCAFEF00D);
    preload(10'h041, 32'h11112222);
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_pressure();
    test_reset_mid();
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
